// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between an ALU result producer
// (multi-byte frames, LSB byte first) and a register-file producer (one byte).
// Each producer has a one-entry holding buffer; a round-robin FSM serialises
// frames toward the TX synchroniser with a level-based four-phase handshake.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | no frame owner; waiting for a full buffer and TX_BUSY=0
//   S_SEND    | byte request held high, waiting for TX_DATA_OK or timeout
//   S_RELEASE | request dropped, waiting for TX_DATA_OK=0 and TX_BUSY=0
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [RESULT_WIDTH-1:0] ALU_DATA,
  input  logic                    ALU_VALID,
  output logic                    ALU_READY,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  input  logic                    RF_VALID,
  output logic                    RF_READY,
  input  logic                    TX_BUSY,
  input  logic                    TX_DATA_OK,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VALID,
  output logic [1:0]              GRANT,
  output logic                    OVERRUN,
  output logic                    TIMEOUT_ERR
);

  localparam int NB    = RESULT_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE} state_t;

  logic [RESULT_WIDTH-1:0]          alu_buf_q;
  logic                             alu_full_q;
  logic [DATA_WIDTH-1:0]            rf_buf_q;
  logic                             rf_full_q;
  logic                             overrun_q;

  state_t                           state_q;
  logic [1:0]                       grant_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic                             last_rf_q;
  logic                             dropped_q;
  logic [DATA_WIDTH-1:0]            tx_data_q;
  logic                             tx_valid_q;
  logic                             tmo_q;

  logic [NB-1:0][DATA_WIDTH-1:0]    alu_bytes;
  logic [IDX_W-1:0]                 idx_d;
  logic                             timeout_hit;
  logic                             frame_last;
  logic                             release_go;
  logic                             frame_end;
  logic                             alu_clr;
  logic                             rf_clr;
  logic                             pick_rf;

  assign alu_bytes   = alu_buf_q;
  assign idx_d       = idx_q + IDX_W'(1);
  assign timeout_hit = (state_q == S_SEND) && !TX_DATA_OK && (cnt_q == CNT_LAST);
  // A dropped frame ends after its release phase regardless of remaining bytes.
  assign frame_last  = dropped_q || grant_q[1] || (idx_q == IDX_LAST);
  assign release_go  = (state_q == S_RELEASE) && !TX_DATA_OK && !TX_BUSY;
  assign frame_end   = release_go && frame_last;
  // A timed-out buffer was already cleared, so frame end must not clear it again.
  assign alu_clr     = grant_q[0] && (timeout_hit || (frame_end && !dropped_q));
  assign rf_clr      = grant_q[1] && (timeout_hit || (frame_end && !dropped_q));
  // On a tie the requester that did not own the last frame wins.
  assign pick_rf     = rf_full_q && (!alu_full_q || !last_rf_q);

  assign ALU_READY   = ~alu_full_q;
  assign RF_READY    = ~rf_full_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VALID  = tx_valid_q;
  assign GRANT       = grant_q;
  assign OVERRUN     = overrun_q;
  assign TIMEOUT_ERR = tmo_q;

  // Holding buffers: load on VALID&READY, clear at frame end or timeout; flag ignored offers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_buf_q  <= '0;
      alu_full_q <= 1'b0;
      rf_buf_q   <= '0;
      rf_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (ALU_VALID && !alu_full_q) begin
        alu_buf_q  <= ALU_DATA;
        alu_full_q <= 1'b1;
      end else if (alu_clr) begin
        alu_full_q <= 1'b0;
      end
      if (RF_VALID && !rf_full_q) begin
        rf_buf_q  <= RF_DATA;
        rf_full_q <= 1'b1;
      end else if (rf_clr) begin
        rf_full_q <= 1'b0;
      end
      overrun_q <= (ALU_VALID && alu_full_q) || (RF_VALID && rf_full_q);
    end
  end

  // Arbitration and byte handshake FSM with registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      idx_q      <= '0;
      cnt_q      <= '0;
      last_rf_q  <= 1'b1;
      dropped_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!TX_BUSY && (alu_full_q || rf_full_q)) begin
            if (pick_rf) begin
              grant_q   <= 2'b10;
              tx_data_q <= rf_buf_q;
            end else begin
              grant_q   <= 2'b01;
              tx_data_q <= alu_bytes[0];
            end
            tx_valid_q <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            dropped_q  <= 1'b0;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (TX_DATA_OK) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            tx_valid_q <= 1'b0;
            tmo_q      <= 1'b1;
            dropped_q  <= 1'b1;
            last_rf_q  <= grant_q[1];
            state_q    <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (release_go) begin
            if (!frame_last) begin
              idx_q      <= idx_d;
              tx_data_q  <= alu_bytes[idx_d];
              tx_valid_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_SEND;
            end else begin
              last_rf_q <= grant_q[1];
              grant_q   <= 2'b00;
              idx_q     <= '0;
              dropped_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset values, single ALU frame,
// round-robin ordering, TX_BUSY hold-off, ack timeout, overrun and async reset.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        RST;
  logic [15:0] ALU_DATA;
  logic        ALU_VALID;
  logic        ALU_READY;
  logic [7:0]  RF_DATA;
  logic        RF_VALID;
  logic        RF_READY;
  logic        TX_BUSY;
  logic        TX_DATA_OK;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VALID;
  logic [1:0]  GRANT;
  logic        OVERRUN;
  logic        TIMEOUT_ERR;

  int tests;
  int fails;

  logic       auto_ok;
  logic [2:0] hist;
  logic       prev_valid;
  logic [7:0] bq[$];
  logic [1:0] gq[$];

  uart_tx_arbiter #(.DATA_WIDTH(8), .RESULT_WIDTH(16), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_DATA(ALU_DATA), .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY),
    .RF_DATA(RF_DATA), .RF_VALID(RF_VALID), .RF_READY(RF_READY),
    .TX_BUSY(TX_BUSY), .TX_DATA_OK(TX_DATA_OK),
    .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID), .GRANT(GRANT),
    .OVERRUN(OVERRUN), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Transmitter model: accept follows the request level a few cycles later.
  always @(negedge CLK) begin
    if (auto_ok) begin
      hist = {hist[1:0], TX_D_VALID};
      TX_DATA_OK = hist[2];
    end else begin
      hist = 3'b000;
    end
  end

  // Record every new byte request with its owner.
  always @(negedge CLK) begin
    if (RST) begin
      prev_valid = 1'b0;
    end else begin
      if (TX_D_VALID && !prev_valid) begin
        bq.push_back(TX_P_DATA);
        gq.push_back(GRANT);
      end
      prev_valid = TX_D_VALID;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    RST = 1'b1;
    ALU_VALID = 1'b0; RF_VALID = 1'b0; ALU_DATA = '0; RF_DATA = '0;
    TX_BUSY = 1'b0; TX_DATA_OK = 1'b0; auto_ok = 1'b1; hist = 3'b000;
    repeat (2) @(negedge CLK);
    bq.delete(); gq.delete();
    RST = 1'b0;
  endtask

  task automatic offer(input logic a_en, input logic [15:0] a_d,
                       input logic r_en, input logic [7:0] r_d);
    @(negedge CLK);
    ALU_VALID = a_en; ALU_DATA = a_d; RF_VALID = r_en; RF_DATA = r_d;
    @(negedge CLK);
    ALU_VALID = 1'b0; RF_VALID = 1'b0;
  endtask

  task automatic wait_frame(input int n, input string name);
    int k;
    k = 0;
    while (!(bq.size() >= n && GRANT == 2'b00 && !TX_D_VALID) && k < 300) begin
      @(negedge CLK);
      k++;
    end
    tests++;
    if (k >= 300) begin
      fails++;
      $display("FAIL %s_wait: got %0d bytes, required %0d before cycle limit", name, bq.size(), n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ALU_VALID = 1'b0; RF_VALID = 1'b0; ALU_DATA = '0; RF_DATA = '0;
    TX_BUSY = 1'b0; TX_DATA_OK = 1'b0; auto_ok = 1'b1; hist = 3'b000;
    repeat (2) @(negedge CLK);
    tests++;
    if ({ALU_READY, RF_READY, TX_D_VALID, GRANT, OVERRUN, TIMEOUT_ERR, TX_P_DATA} !==
        {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required %h",
               {ALU_READY, RF_READY, TX_D_VALID, GRANT, OVERRUN, TIMEOUT_ERR, TX_P_DATA},
               {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00});
    end
    bq.delete(); gq.delete();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if ({TX_D_VALID, GRANT} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got %b, required 000", {TX_D_VALID, GRANT});
    end
  endtask

  task automatic test_single_alu();
    @(negedge CLK);
    ALU_DATA = 16'hA55A; ALU_VALID = 1'b1;
    tests++;
    if (ALU_READY !== 1'b1) begin
      fails++; $display("FAIL alu_ready_before: got %b, required 1", ALU_READY);
    end
    @(negedge CLK);
    ALU_VALID = 1'b0;
    tests++;
    if ({ALU_READY, TX_D_VALID} !== 2'b00) begin
      fails++; $display("FAIL alu_latency_n1: got %b, required 00", {ALU_READY, TX_D_VALID});
    end
    @(negedge CLK);
    tests++;
    if ({TX_D_VALID, GRANT, TX_P_DATA} !== {1'b1, 2'b01, 8'h5A}) begin
      fails++; $display("FAIL alu_first_byte: got %h, required %h",
                        {TX_D_VALID, GRANT, TX_P_DATA}, {1'b1, 2'b01, 8'h5A});
    end
    wait_frame(2, "alu_frame");
    tests++;
    if (bq.size() != 2 || bq[0] !== 8'h5A || bq[1] !== 8'hA5 || gq[0] !== 2'b01 || gq[1] !== 2'b01) begin
      fails++; $display("FAIL alu_bytes: got %p grants %p, required 5a a5 grants 1 1", bq, gq);
    end
    tests++;
    if (ALU_READY !== 1'b1) begin
      fails++; $display("FAIL alu_ready_after: got %b, required 1", ALU_READY);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    offer(1'b1, 16'h1234, 1'b1, 8'hC3);
    wait_frame(3, "rr_pair1");
    tests++;
    if (bq.size() != 3 || bq[0] !== 8'h34 || bq[1] !== 8'h12 || bq[2] !== 8'hC3 ||
        gq[0] !== 2'b01 || gq[2] !== 2'b10) begin
      fails++; $display("FAIL rr_pair1: got %p grants %p, required 34 12 c3 grants 1 1 2", bq, gq);
    end
    // An ALU-only frame leaves the pointer on ALU, so the next tie goes to RF.
    bq.delete(); gq.delete();
    offer(1'b1, 16'hBEEF, 1'b0, 8'h00);
    wait_frame(2, "rr_alu_only");
    tests++;
    if (bq.size() != 2 || bq[0] !== 8'hEF || bq[1] !== 8'hBE) begin
      fails++; $display("FAIL rr_alu_only: got %p, required ef be", bq);
    end
    bq.delete(); gq.delete();
    offer(1'b1, 16'h5678, 1'b1, 8'h9E);
    wait_frame(3, "rr_pair2");
    tests++;
    if (bq.size() != 3 || bq[0] !== 8'h9E || bq[1] !== 8'h78 || bq[2] !== 8'h56 ||
        gq[0] !== 2'b10 || gq[1] !== 2'b01) begin
      fails++; $display("FAIL rr_pair2: got %p grants %p, required 9e 78 56 grants 2 1 1", bq, gq);
    end
  endtask

  task automatic test_busy_hold();
    int highs;
    highs = 0;
    bq.delete(); gq.delete();
    TX_BUSY = 1'b1;
    offer(1'b0, 16'h0000, 1'b1, 8'h77);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (TX_D_VALID) highs++;
    end
    tests++;
    if (highs != 0 || RF_READY !== 1'b0) begin
      fails++; $display("FAIL busy_hold: got %0d request cycles ready=%b, required 0 ready=0", highs, RF_READY);
    end
    TX_BUSY = 1'b0;
    @(negedge CLK);
    tests++;
    if ({TX_D_VALID, GRANT, TX_P_DATA} !== {1'b1, 2'b10, 8'h77}) begin
      fails++; $display("FAIL busy_release: got %h, required %h",
                        {TX_D_VALID, GRANT, TX_P_DATA}, {1'b1, 2'b10, 8'h77});
    end
    wait_frame(1, "busy_frame");
  endtask

  task automatic test_timeout();
    int highs;
    int tmos;
    highs = 0; tmos = 0;
    auto_ok = 1'b0; TX_DATA_OK = 1'b0;
    bq.delete(); gq.delete();
    offer(1'b0, 16'h0000, 1'b1, 8'h11);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (TX_D_VALID) highs++;
      if (TIMEOUT_ERR) tmos++;
    end
    tests++;
    if (highs != 8) begin
      fails++; $display("FAIL timeout_req_cycles: got %0d, required 8", highs);
    end
    tests++;
    if (tmos != 1) begin
      fails++; $display("FAIL timeout_err_pulses: got %0d, required 1", tmos);
    end
    tests++;
    if ({GRANT, RF_READY, TX_D_VALID} !== 4'b0010) begin
      fails++; $display("FAIL timeout_freed: got %b, required 0010", {GRANT, RF_READY, TX_D_VALID});
    end
    auto_ok = 1'b1;
    bq.delete(); gq.delete();
    offer(1'b0, 16'h0000, 1'b1, 8'h22);
    wait_frame(1, "timeout_next");
    tests++;
    if (bq.size() != 1 || bq[0] !== 8'h22) begin
      fails++; $display("FAIL timeout_next_byte: got %p, required 22", bq);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    pulses = 0;
    bq.delete(); gq.delete();
    TX_BUSY = 1'b1;
    offer(1'b0, 16'h0000, 1'b1, 8'h3C);
    RF_DATA = 8'hFF; RF_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (OVERRUN) pulses++;
      if (i == 2) RF_VALID = 1'b0;
    end
    tests++;
    if (pulses != 3) begin
      fails++; $display("FAIL overrun_pulses: got %0d, required 3", pulses);
    end
    TX_BUSY = 1'b0;
    wait_frame(1, "overrun_frame");
    tests++;
    if (bq.size() != 1 || bq[0] !== 8'h3C) begin
      fails++; $display("FAIL overrun_data_kept: got %p, required 3c", bq);
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    bq.delete(); gq.delete();
    offer(1'b1, 16'hCAFE, 1'b0, 8'h00);
    while (bq.size() < 2 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    tests++;
    if (bq.size() < 2 || bq[1] !== 8'hCA || TX_D_VALID !== 1'b1) begin
      fails++; $display("FAIL rst_second_byte: got %p valid=%b, required fe ca valid=1", bq, TX_D_VALID);
    end
    #2 RST = 1'b1;
    #1;
    tests++;
    if ({ALU_READY, RF_READY, TX_D_VALID, GRANT, OVERRUN, TIMEOUT_ERR, TX_P_DATA} !==
        {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL rst_async_outputs: got %h, required %h",
               {ALU_READY, RF_READY, TX_D_VALID, GRANT, OVERRUN, TIMEOUT_ERR, TX_P_DATA},
               {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00});
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    tests++;
    if ({ALU_READY, TX_D_VALID, GRANT} !== 4'b1000 || bq.size() != 2) begin
      fails++; $display("FAIL rst_frame_lost: got %b bytes=%0d, required 1000 bytes=2",
                        {ALU_READY, TX_D_VALID, GRANT}, bq.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prev_valid = 1'b0;
    test_reset();
    test_single_alu();
    test_round_robin();
    test_busy_hold();
    test_timeout();
    test_overrun();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
